// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M multiply sequencing controller.
//   mul_op_t    : funct3 encodings of the supported multiply operations
//   mul_state_t : controller FSM states
//   mul_cache_t : product cache entry, used when MUL_FUSE_EN is defined
//   sel_word    : picks the architectural result word from a 64-bit product
package mul_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned PROD_W         = 64;
    localparam int unsigned MUL_CYCLES_MAX = 8;
    localparam int unsigned CNT_W          = $clog2(MUL_CYCLES_MAX);

    typedef enum logic [2:0] {
        MUL_OP_MUL    = 3'b000,
        MUL_OP_MULH   = 3'b001,
        MUL_OP_MULHSU = 3'b010,
        MUL_OP_MULHU  = 3'b011
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic              s1;
        logic              s2;
        logic [PROD_W-1:0] p;
    } mul_cache_t;

    // MUL returns the low word; every MULH* variant returns the high word.
    function automatic logic [XLEN-1:0] sel_word(input mul_op_t op, input logic [PROD_W-1:0] p);
        return (op == MUL_OP_MUL) ? p[XLEN-1:0] : p[PROD_W-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response handshake bundle between dispatch/writeback and mul_ctrl.
//   req_*  : request channel (valid/ready, funct3, operands, tag)
//   resp_* : response channel (valid/ready, result word, tag)
// Modports: master = dispatch/writeback side, slave = mul_ctrl.
interface mul_ctrl_if
    import mul_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) ();

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_rs1;
    logic [XLEN-1:0]   req_rs2;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [TAG_W-1:0]  resp_tag;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Combinational sign handling around the unsigned multiplier tree.
//   op, rs1, rs2        -> mag_a_c, mag_b_c : operand magnitudes fed to the tree
//                       -> s1_c, s2_c       : operand signs for this op
//   prod, neg           -> prod_fix_c       : two's-complement corrected product
//   word_op, word_src   -> word_c           : selected 32-bit result word
module mul_sign_fix
    import mul_pkg::*;
(
    input  mul_op_t            op,
    input  logic [XLEN-1:0]    rs1,
    input  logic [XLEN-1:0]    rs2,
    output logic [XLEN-1:0]    mag_a_c,
    output logic [XLEN-1:0]    mag_b_c,
    output logic               s1_c,
    output logic               s2_c,
    input  logic [PROD_W-1:0]  prod,
    input  logic               neg,
    output logic [PROD_W-1:0]  prod_fix_c,
    input  mul_op_t            word_op,
    input  logic [PROD_W-1:0]  word_src,
    output logic [XLEN-1:0]    word_c
);

    // 0x80000000 negates to itself, which is still the correct unsigned magnitude.
    always_comb begin
        s1_c       = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? rs1[XLEN-1] : 1'b0;
        s2_c       = (op == MUL_OP_MULH) ? rs2[XLEN-1] : 1'b0;
        mag_a_c    = s1_c ? (~rs1 + XLEN'(1)) : rs1;
        mag_b_c    = s2_c ? (~rs2 + XLEN'(1)) : rs2;
        prod_fix_c = neg ? (~prod + PROD_W'(1)) : prod;
        word_c     = sel_word(word_op, word_src);
    end

endmodule

// File: rtl/mul_ctrl.sv
// RV32M multiply functional-unit sequencer in front of an external
// combinational 32x32 unsigned tree (treated as a MUL_CYCLES multicycle path).
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : kills any in-flight or held operation
//   bus (slave)   : request/response handshake (mul_ctrl_if)
//   mul_a, mul_b  : registered operand magnitudes to the tree
//   mul_op1sign/2 : tied 0, tree always used unsigned
//   mul_f         : unsigned 64-bit product from the tree
// Optional: define MUL_FUSE_EN for a 1-entry product cache that answers a
// repeated operand pair one cycle after accept.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    mul_ctrl_if.slave          bus,
    output logic [XLEN-1:0]    mul_a,
    output logic [XLEN-1:0]    mul_b,
    output logic               mul_op1sign,
    output logic               mul_op2sign,
    input  logic [PROD_W-1:0]  mul_f
);

    mul_state_t        state;
    mul_state_t        state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic              resp_valid_q;
    logic              resp_valid_d;
    logic [XLEN-1:0]   resp_data_q;
    logic [XLEN-1:0]   resp_data_d;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    mul_op_t           op_q;

    logic              req_ready_c;
    logic              load_c;
    logic              finish_c;
    mul_op_t           req_op_c;
    logic [XLEN-1:0]   mag_a_c;
    logic [XLEN-1:0]   mag_b_c;
    logic              s1_c;
    logic              s2_c;
    logic [PROD_W-1:0] prod_fix_c;
    logic [PROD_W-1:0] word_src_c;
    logic [XLEN-1:0]   word_c;
    logic              hit_c;
    logic              hit_q;
    logic [PROD_W-1:0] cache_p_c;

    assign req_op_c    = mul_op_t'(bus.req_funct3);
    assign req_ready_c = !flush && ((state == IDLE) || (state == DONE && bus.resp_ready));

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = tag_q;
    assign mul_op1sign    = 1'b0;
    assign mul_op2sign    = 1'b0;

    // A cache hit replaces the tree output; the cached product is already sign-corrected.
    assign word_src_c = hit_q ? cache_p_c : prod_fix_c;

    mul_sign_fix u_sign_fix (
        .op         (req_op_c),
        .rs1        (bus.req_rs1),
        .rs2        (bus.req_rs2),
        .mag_a_c    (mag_a_c),
        .mag_b_c    (mag_b_c),
        .s1_c       (s1_c),
        .s2_c       (s2_c),
        .prod       (mul_f),
        .neg        (neg_q),
        .prod_fix_c (prod_fix_c),
        .word_op    (op_q),
        .word_src   (word_src_c),
        .word_c     (word_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, counter and response; flush overrides everything.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        load_c       = 1'b0;
        finish_c     = 1'b0;
        if (flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            resp_valid_d = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        load_c = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        finish_c     = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_data_d  = word_c;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = IDLE;
                        if (bus.req_valid) begin
                            load_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // A hit only needs the single BUSY cycle that reads the cache.
            if (load_c) begin
                state_d = BUSY;
                cnt_d   = hit_c ? '0 : CNT_W'(MUL_CYCLES - 1);
            end
        end
    end

    // Operand, tag and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            tag_q        <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            neg_q        <= 1'b0;
            op_q         <= MUL_OP_MUL;
        end else begin
            cnt          <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            if (load_c) begin
                mul_a <= mag_a_c;
                mul_b <= mag_b_c;
                neg_q <= s1_c ^ s2_c;
                op_q  <= req_op_c;
                tag_q <= bus.req_tag;
            end
        end
    end

`ifdef MUL_FUSE_EN
    mul_cache_t       cache_q;
    logic             cache_vld;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic             s1_q;
    logic             s2_q;

    // The low word is sign-independent, so MUL hits regardless of the cached sign pair.
    assign hit_c = cache_vld
                && (bus.req_rs1 == cache_q.rs1)
                && (bus.req_rs2 == cache_q.rs2)
                && (((s1_c == cache_q.s1) && (s2_c == cache_q.s2)) || (req_op_c == MUL_OP_MUL));
    assign cache_p_c = cache_q.p;

    // Product cache, refreshed by every completion that went through the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_q   <= '0;
            cache_vld <= 1'b0;
            hit_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
        end else begin
            if (load_c) begin
                hit_q <= hit_c;
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
                s1_q  <= s1_c;
                s2_q  <= s2_c;
            end
            if (flush) begin
                cache_vld <= 1'b0;
            end else if (finish_c && !hit_q) begin
                cache_q   <= '{rs1: rs1_q, rs2: rs2_q, s1: s1_q, s2: s2_q, p: prod_fix_c};
                cache_vld <= 1'b1;
            end
        end
    end
`else
    assign hit_c     = 1'b0;
    assign hit_q     = 1'b0;
    assign cache_p_c = '0;
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: the driver pushes hand-computed results and
// latencies when a request is accepted; a negedge monitor pops and compares
// whenever the controller presents a response.
module tb_mul_ctrl;

    localparam int unsigned MUL_CYCLES = 2;
    localparam int unsigned TAG_W      = 5;
`ifdef MUL_FUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = MUL_CYCLES;
`endif

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_op1sign;
    logic        mul_op2sign;
    logic [63:0] mul_f;

    mul_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_op1sign (mul_op1sign),
        .mul_op2sign (mul_op2sign),
        .mul_f       (mul_f)
    );

    // Model of the external unsigned tree.
    always_comb mul_f = {32'b0, mul_a} * {32'b0, mul_b};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen = 0;
    bit   stray = 0;
    int   last_pop_cyc = -1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compare on first sight of a response, then watch the hold phase.
    always @(negedge clk) begin
        if (rst) begin
            if (seen && !stray && sbq.size() > 0) void'(sbq.pop_front());
            seen  = 0;
            stray = 0;
        end else if (bus.resp_valid) begin
            if (!seen) begin
                seen = 1;
                if (sbq.size() == 0) begin
                    stray = 1;
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    check("resp_data", 64'(bus.resp_data), 64'(sbq[0].data));
                    check("resp_tag", 64'(bus.resp_tag), 64'(sbq[0].tag));
                    check("resp_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                end
            end else if (!bus.resp_ready && !stray) begin
                check("hold_data", 64'(bus.resp_data), 64'(sbq[0].data));
                check("hold_tag", 64'(bus.resp_tag), 64'(sbq[0].tag));
            end
            if (!bus.resp_ready) check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            if (bus.resp_ready) begin
                if (!stray) void'(sbq.pop_front());
                seen  = 0;
                stray = 0;
                last_pop_cyc = cyc + 1;
            end
        end else if (seen) begin
            check("resp_dropped", 64'd1, 64'd0);
            if (!stray && sbq.size() > 0) void'(sbq.pop_front());
            seen  = 0;
            stray = 0;
        end
    end

    // Present a request from posedge+1 until accepted; returns the accept cycle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] exp, input int lat,
                         input bit push, output int acc);
        int budget;
        budget = 0;
        acc = -1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_tag    = t;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            budget++;
            if (budget > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        acc = cyc + 1;
        if (push) sbq.push_back('{exp, t, acc, lat});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (sbq.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int budget;
        budget = 0;
        while (!bus.resp_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("valid_seen", 64'(bus.resp_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // MUL: operands passed unsigned, low word returned.
        issue(F_MUL, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'hFFFFFFFE, MUL_CYCLES, 1, acc);
        check("mul_a_mul", 64'(mul_a), 64'hFFFFFFFF);
        check("mul_b_mul", 64'(mul_b), 64'h00000002);
        check("op1sign", 64'(mul_op1sign), 64'd0);
        check("op2sign", 64'(mul_op2sign), 64'd0);
        wait_idle();

        // MULH corner cases, issued back to back.
        issue(F_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000, MUL_CYCLES, 1, acc);
        check("mul_a_mulh", 64'(mul_a), 64'h00000001);
        check("mul_b_mulh", 64'(mul_b), 64'h00000001);
        issue(F_MULH, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000, MUL_CYCLES, 1, acc);
        check("mul_a_min", 64'(mul_a), 64'h80000000);
        issue(F_MULH, 32'h80000000, 32'h00000001, 5'd6, 32'hFFFFFFFF, MUL_CYCLES, 1, acc);
        issue(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, MUL_CYCLES, 1, acc);
        check("mul_b_mulhsu", 64'(mul_b), 64'hFFFFFFFF);
        issue(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, MUL_CYCLES, 1, acc);
        wait_idle();

        // Backpressure, then accept on the same edge as the handshake.
        bus.resp_ready = 1'b0;
        issue(F_MUL, 32'd7, 32'd6, 5'd9, 32'd42, MUL_CYCLES, 1, acc);
        wait_valid();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        issue(F_MUL, 32'h00001234, 32'h00000010, 5'd10, 32'h00012340, MUL_CYCLES, 1, acc);
        check("b2b_same_cycle", 64'(acc), 64'(last_pop_cyc));
        wait_idle();

        // Flush during BUSY; the request offered in the flush cycle is dropped.
        issue(F_MUL, 32'd5, 32'd5, 5'd11, 32'd25, MUL_CYCLES, 0, acc);
        flush = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F_MUL;
        bus.req_rs1    = 32'd2;
        bus.req_rs2    = 32'd2;
        bus.req_tag    = 5'd12;
        @(negedge clk);
        check("flush_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("flush_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset while a result is held in DONE.
        bus.resp_ready = 1'b0;
        issue(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, MUL_CYCLES, 1, acc);
        wait_valid();
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_async_data", 64'(bus.resp_data), 64'd0);
        check("rst_async_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(F_MULH, 32'h80000000, 32'h00000001, 5'd17, 32'hFFFFFFFF, MUL_CYCLES, 1, acc);
        wait_idle();

        // Same operand pair: MULH, then MUL (cache hit when fused), then MUL after flush.
        issue(F_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd20, 32'hF8CC93D6, MUL_CYCLES, 1, acc);
        issue(F_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd21, 32'h242D2080, HIT_LAT, 1, acc);
        wait_idle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(F_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd22, 32'h242D2080, MUL_CYCLES, 1, acc);
        wait_idle();

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
